// File: rtl/uart_rx.sv
// uart_rx: 8N1 serial receiver with a small receive FIFO on the I/O bus.
// Ports: clk, resetn, en, write_enable[2:0], addr[23:0], data_in[31:0],
//   data_out[31:0] (tri-stated when not selected), uart_rxd, rx_irq.
//   0x4 read pops the FIFO head; 0x5 read is status, 0x5 write clears flags.
module uart_rx #(
    parameter int CLKS_PER_BIT = 5000,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        en,
    input  logic [2:0]  write_enable,
    input  logic [23:0] addr,
    input  logic [31:0] data_in,
    output logic [31:0] data_out,
    input  logic        uart_rxd,
    output logic        rx_irq
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [15:0] BIT_LAST  = 16'(CLKS_PER_BIT - 1);
    localparam logic [15:0] HALF_LAST = 16'(CLKS_PER_BIT / 2 - 1);
    localparam logic [AW:0] FULL_CNT  = (AW + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    state_t        state;
    logic          rx_meta;
    logic          rxs;
    logic          rxs_d;
    logic [15:0]   baud_cnt;
    logic [2:0]    bit_idx;
    logic [7:0]    shift;

    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          overrun;
    logic          frame_err;
    logic          rd_prev;

    logic          stop_sample;
    logic          stop_ok;
    logic          rd_access;
    logic          pop;
    logic          push;
    logic          full;
    logic          not_empty;
    logic          set_ovr;
    logic          set_ferr;
    logic          clr_wr;
    logic          sel_data;
    logic          sel_stat;
    logic [31:0]   rd_mux;
    logic          unused;

    assign unused = ^{write_enable[1:0], addr[23:4], data_in[31:3], data_in[0]};

    // Two-flop synchroniser; rxs_d keeps the previous value so IDLE
    // can insist on a fresh falling edge before starting a frame.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rx_meta <= 1'b1;
            rxs     <= 1'b1;
            rxs_d   <= 1'b1;
        end else begin
            rx_meta <= uart_rxd;
            rxs     <= rx_meta;
            rxs_d   <= rxs;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state    <= IDLE;
            baud_cnt <= '0;
            bit_idx  <= '0;
            shift    <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    baud_cnt <= '0;
                    if (!rxs && rxs_d) begin
                        state <= START;
                    end
                end
                START: begin
                    if (baud_cnt == HALF_LAST) begin
                        baud_cnt <= '0;
                        bit_idx  <= '0;
                        state    <= rxs ? IDLE : DATA;
                    end else begin
                        baud_cnt <= baud_cnt + 16'd1;
                    end
                end
                DATA: begin
                    if (baud_cnt == BIT_LAST) begin
                        baud_cnt       <= '0;
                        shift[bit_idx] <= rxs;
                        if (bit_idx == 3'd7) begin
                            state <= STOP;
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 16'd1;
                    end
                end
                STOP: begin
                    if (baud_cnt == BIT_LAST) begin
                        baud_cnt <= '0;
                        state    <= IDLE;
                    end else begin
                        baud_cnt <= baud_cnt + 16'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign stop_sample = (state == STOP) && (baud_cnt == BIT_LAST);
    assign stop_ok     = stop_sample && rxs;

    assign full      = (count == FULL_CNT);
    assign not_empty = (count != '0);

    assign rd_access = en && (write_enable == 3'b000) && (addr[3:0] == 4'h4);
    assign pop       = rd_access && !rd_prev && not_empty;
    // A same-cycle pop frees a slot, so a full FIFO still accepts the byte.
    assign push      = stop_ok && (!full || pop);
    assign set_ovr   = stop_ok && full && !pop;
    assign set_ferr  = stop_sample && !rxs;
    assign clr_wr    = en && write_enable[2] && (addr[3:0] == 4'h5);

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= shift;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            overrun   <= 1'b0;
            frame_err <= 1'b0;
            rd_prev   <= 1'b0;
        end else begin
            rd_prev <= rd_access;
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push && !pop) begin
                count <= count + 1'b1;
            end else if (pop && !push) begin
                count <= count - 1'b1;
            end
            // Setting a flag takes priority over a same-cycle clear.
            if (set_ovr) begin
                overrun <= 1'b1;
            end else if (clr_wr && data_in[2]) begin
                overrun <= 1'b0;
            end
            if (set_ferr) begin
                frame_err <= 1'b1;
            end else if (clr_wr && data_in[1]) begin
                frame_err <= 1'b0;
            end
        end
    end

    assign rx_irq = not_empty;

    assign sel_data = en && (addr[3:0] == 4'h4);
    assign sel_stat = en && (addr[3:0] == 4'h5);

    always_comb begin
        rd_mux = '0;
        if (sel_data) begin
            rd_mux = not_empty ? {24'b0, mem[rd_ptr]} : 32'b0;
        end else if (sel_stat) begin
            rd_mux = {27'b0, full, (state != IDLE), overrun, frame_err, not_empty};
        end
    end

    assign data_out = (sel_data || sel_stat) ? rd_mux : {32{1'bz}};

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed self-checking bench for uart_rx.
// Runs with CLKS_PER_BIT = 16 and FIFO_DEPTH = 4.
module tb_uart_rx;

    localparam int CPB = 16;

    logic        clk;
    logic        resetn;
    logic        en;
    logic [2:0]  write_enable;
    logic [23:0] addr;
    logic [31:0] data_in;
    wire  [31:0] data_out;
    logic        uart_rxd;
    logic        rx_irq;

    int n_cmp;
    int n_err;

    uart_rx #(
        .CLKS_PER_BIT(CPB),
        .FIFO_DEPTH(4)
    ) dut (
        .clk(clk),
        .resetn(resetn),
        .en(en),
        .write_enable(write_enable),
        .addr(addr),
        .data_in(data_in),
        .data_out(data_out),
        .uart_rxd(uart_rxd),
        .rx_irq(rx_irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic line_bit(input logic b);
        uart_rxd = b;
        repeat (CPB) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop);
        @(negedge clk);
        line_bit(1'b0);
        for (int i = 0; i < 8; i++) line_bit(b[i]);
        line_bit(stop);
        uart_rxd = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic bus_read(input logic [3:0] a, output logic [31:0] d);
        @(negedge clk);
        en = 1'b1;
        write_enable = 3'b000;
        addr = {20'h0, a};
        #1 d = data_out;
        @(negedge clk);
        en = 1'b0;
        addr = '0;
    endtask

    task automatic bus_write(input logic [3:0] a, input logic [31:0] d);
        @(negedge clk);
        en = 1'b1;
        write_enable = 3'b100;
        addr = {20'h0, a};
        data_in = d;
        @(negedge clk);
        en = 1'b0;
        write_enable = 3'b000;
        addr = '0;
        data_in = '0;
    endtask

    task automatic test_reset();
        logic [31:0] d;
        resetn = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp++;
        if (rx_irq !== 1'b0) begin
            n_err++;
            $display("FAIL reset_irq: got %b want 0", rx_irq);
        end
        resetn = 1'b1;
        bus_read(4'h5, d);
        n_cmp++;
        if (d !== 32'h0) begin
            n_err++;
            $display("FAIL reset_status: got %h want 0", d);
        end
    endtask

    task automatic test_reset_mid_frame();
        logic [31:0] d;
        logic [7:0] b;
        b = 8'h55;
        @(negedge clk);
        line_bit(1'b0);
        for (int i = 0; i < 3; i++) line_bit(b[i]);
        uart_rxd = b[3];
        repeat (CPB / 2) @(negedge clk);
        resetn = 1'b0;
        uart_rxd = 1'b1;
        en = 1'b1;
        write_enable = 3'b000;
        addr = 24'h5;
        #1 d = data_out;
        n_cmp++;
        if (d !== 32'h0) begin
            n_err++;
            $display("FAIL midreset_status: got %h want 0", d);
        end
        @(negedge clk);
        resetn = 1'b1;
        en = 1'b0;
        addr = '0;
        repeat (12 * CPB) @(negedge clk);
        bus_read(4'h5, d);
        n_cmp++;
        if (d !== 32'h0) begin
            n_err++;
            $display("FAIL midreset_after: got %h want 0", d);
        end
        send_byte(8'hA5, 1'b1);
        n_cmp++;
        if (rx_irq !== 1'b1) begin
            n_err++;
            $display("FAIL midreset_irq: got %b want 1", rx_irq);
        end
        bus_read(4'h4, d);
        n_cmp++;
        if (d !== 32'h0000_00A5) begin
            n_err++;
            $display("FAIL midreset_data: got %h want a5", d);
        end
    endtask

    task automatic test_single_byte();
        logic [31:0] d;
        send_byte(8'h3C, 1'b1);
        n_cmp++;
        if (rx_irq !== 1'b1) begin
            n_err++;
            $display("FAIL single_irq: got %b want 1", rx_irq);
        end
        bus_read(4'h5, d);
        n_cmp++;
        if (d !== 32'h01) begin
            n_err++;
            $display("FAIL single_status: got %h want 01", d);
        end
        bus_read(4'h4, d);
        n_cmp++;
        if (d !== 32'h3C) begin
            n_err++;
            $display("FAIL single_data: got %h want 3c", d);
        end
        bus_read(4'h5, d);
        n_cmp++;
        if (d !== 32'h00) begin
            n_err++;
            $display("FAIL single_status_after: got %h want 00", d);
        end
        n_cmp++;
        if (rx_irq !== 1'b0) begin
            n_err++;
            $display("FAIL single_irq_after: got %b want 0", rx_irq);
        end
    endtask

    task automatic test_glitch();
        logic [31:0] d;
        @(negedge clk);
        uart_rxd = 1'b0;
        repeat (CPB / 4) @(negedge clk);
        uart_rxd = 1'b1;
        bus_read(4'h5, d);
        n_cmp++;
        if (d !== 32'h08) begin
            n_err++;
            $display("FAIL glitch_busy: got %h want 08", d);
        end
        repeat (2 * CPB) @(negedge clk);
        bus_read(4'h5, d);
        n_cmp++;
        if (d !== 32'h00) begin
            n_err++;
            $display("FAIL glitch_idle: got %h want 00", d);
        end
    endtask

    task automatic test_frame_err();
        logic [31:0] d;
        send_byte(8'h81, 1'b0);
        bus_read(4'h5, d);
        n_cmp++;
        if (d !== 32'h02) begin
            n_err++;
            $display("FAIL ferr_status: got %h want 02", d);
        end
        bus_write(4'h5, 32'h02);
        bus_read(4'h5, d);
        n_cmp++;
        if (d !== 32'h00) begin
            n_err++;
            $display("FAIL ferr_clear: got %h want 00", d);
        end
    endtask

    task automatic test_overrun();
        logic [31:0] d;
        logic [7:0] exp_q [4];
        exp_q = '{8'h01, 8'h02, 8'h03, 8'h04};
        for (int i = 1; i <= 5; i++) send_byte(8'(i), 1'b1);
        bus_read(4'h5, d);
        n_cmp++;
        if (d !== 32'h15) begin
            n_err++;
            $display("FAIL ovr_status: got %h want 15", d);
        end
        for (int i = 0; i < 4; i++) begin
            bus_read(4'h4, d);
            n_cmp++;
            if (d !== {24'h0, exp_q[i]}) begin
                n_err++;
                $display("FAIL ovr_data%0d: got %h want %h", i, d, exp_q[i]);
            end
        end
        bus_read(4'h4, d);
        n_cmp++;
        if (d !== 32'h0) begin
            n_err++;
            $display("FAIL ovr_empty_data: got %h want 0", d);
        end
        bus_read(4'h5, d);
        n_cmp++;
        if (d[0] !== 1'b0) begin
            n_err++;
            $display("FAIL ovr_not_empty: got %b want 0", d[0]);
        end
        bus_write(4'h5, 32'h04);
        bus_read(4'h5, d);
        n_cmp++;
        if (d !== 32'h00) begin
            n_err++;
            $display("FAIL ovr_clear: got %h want 00", d);
        end
    endtask

    task automatic test_pop_edge();
        logic [31:0] d [3];
        logic [31:0] s;
        send_byte(8'h11, 1'b1);
        send_byte(8'h22, 1'b1);
        @(negedge clk);
        en = 1'b1;
        write_enable = 3'b000;
        addr = 24'h4;
        for (int i = 0; i < 3; i++) begin
            #1 d[i] = data_out;
            @(negedge clk);
        end
        en = 1'b0;
        addr = '0;
        n_cmp++;
        if (d[0] !== 32'h11) begin
            n_err++;
            $display("FAIL pop_first: got %h want 11", d[0]);
        end
        n_cmp++;
        if (d[2] !== 32'h22) begin
            n_err++;
            $display("FAIL pop_hold: got %h want 22", d[2]);
        end
        bus_read(4'h5, s);
        n_cmp++;
        if (s !== 32'h01) begin
            n_err++;
            $display("FAIL pop_once_status: got %h want 01", s);
        end
        bus_read(4'h4, s);
        n_cmp++;
        if (s !== 32'h22) begin
            n_err++;
            $display("FAIL pop_second: got %h want 22", s);
        end
        n_cmp++;
        if (rx_irq !== 1'b0) begin
            n_err++;
            $display("FAIL pop_irq: got %b want 0", rx_irq);
        end
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        resetn = 1'b0;
        en = 1'b0;
        write_enable = 3'b000;
        addr = '0;
        data_in = '0;
        uart_rxd = 1'b1;
        test_reset();
        test_reset_mid_frame();
        test_single_byte();
        test_glitch();
        test_frame_err();
        test_overrun();
        test_pop_edge();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- Receive-side companion to the existing memory-mapped UART transmitter. Samples the serial line and deserialises 8N1 frames into a small FIFO.
- Exposes data and status on the same 24-bit I/O bus slot as the GPIO/UART TX registers, at offsets 0x4 and 0x5.
- Directly consumes the physical uart_rxd line and feeds the CPU load path.

Parameters:
- CLKS_PER_BIT, 5000, clk cycles per bit time (48 MHz / 9600 baud); legal range 16..65535.
- FIFO_DEPTH, 4, receive FIFO entries; power of two, 2..16.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- resetn  input  1  asynchronous active-low reset.
- en  input  1  I/O bus select for this device.
- write_enable  input  3  bus write strobes; only bit [2] is a write for this block; 3'b000 means read.
- addr  input  24  bus address; only addr[3:0] decoded.
- data_in  input  32  write data.
- data_out  output  32  read data; 'hz when not selected.
- uart_rxd  input  1  serial line, idle high, asynchronous to clk.
- rx_irq  output  1  high while the FIFO is non-empty.

Behaviour:
- Reset is asynchronous and active-low: resetn low forces all state to reset values immediately, regardless of clk.
- Reset values:
  - FSM = IDLE; FIFO empty (wr_ptr = rd_ptr = count = 0).
  - overrun = 0, frame_err = 0, rx_irq = 0.
  - Synchroniser flops = 1'b1; bit counter = 0; baud counter = 0.
- Input path: uart_rxd passes through a 2-FF synchroniser; the FSM sees only the synchronised value rxs.
- FSM states:
  - IDLE: baud counter held at 0. rxs == 0 -> START.
  - START: count to CLKS_PER_BIT/2 - 1 (integer division). At that cycle, if rxs == 0 -> DATA, reset baud counter and bit index; else (glitch) -> IDLE, nothing stored.
  - DATA: every CLKS_PER_BIT cycles, sample rxs into shift[bit_index]. Bits arrive LSB first. After bit 7 -> STOP.
  - STOP: after CLKS_PER_BIT cycles, sample rxs.
    - rxs == 1: push byte if FIFO not full; if FIFO is full, drop the byte and set overrun.
    - rxs == 0: set frame_err, discard byte.
    - Either case -> IDLE. A line held low re-enters START only after rxs returns high and falls again.
- FIFO:
  - Pointers are log2(FIFO_DEPTH) bits and wrap naturally.
  - count is log2(FIFO_DEPTH)+1 bits.
  - A push and a pop in the same cycle leaves count unchanged and is legal even when full or empty; a pop is evaluated before the full check.
- Bus decode, active only when en = 1:
  - Read 0x4: data_out = {24'b0, fifo_head}, or 32'b0 if empty.
  - Read 0x5: data_out = {27'b0, count_is_full, rx_busy, overrun, frame_err, not_empty}. rx_busy = FSM != IDLE.
  - Any other addr[3:0], or en = 0: data_out = 'hz.
  - data_out is combinational from registered state (same cycle as address).
- Pop rule:
  - A read access is en = 1, write_enable = 0, addr[3:0] = 4'h4.
  - Pop only on the first cycle of a read access, i.e. the condition is true now and was false on the previous cycle (registered flag).
  - Back-to-back reads therefore require the condition to drop for at least one cycle.
  - A pop on an empty FIFO does nothing.
- Write 0x5 with write_enable[2] = 1:
  - data_in[1] = 1 clears frame_err; data_in[2] = 1 clears overrun.
  - If set and clear happen in the same cycle, set wins.
- Writes to 0x4 are ignored.
- rx_irq = (count != 0), registered-state derived, no extra latency.
- Latency: the byte is visible at 0x4 on the cycle after the STOP sample.

Test Plan:
- Reset mid-frame: drive 0x55 with CLKS_PER_BIT = 16, assert resetn low during bit 3 for 1 cycle -> status reads 0x00 immediately, FSM IDLE, no byte stored; the next clean 0xA5 frame is received correctly.
- Single byte: send 0x3C (LSB first, 1 stop) -> 10*CLKS_PER_BIT+small cycles later, rx_irq = 1, status = 0x01; read 0x4 -> 0x3C; status then 0x00, rx_irq = 0.
- Glitch rejection: low pulse of CLKS_PER_BIT/4 cycles on idle line -> FSM returns IDLE, status bit rx_busy falls, FIFO stays empty.
- Framing error: send 0x81 with stop bit driven 0 -> status = 0x02, FIFO empty; write 0x5 with 0x02 -> status 0x00.
- Overrun and full: send 5 bytes 0x01..0x05 with FIFO_DEPTH = 4 and no reads -> status = 0x15 (full, overrun, not_empty); reads return 0x01, 0x02, 0x03, 0x04, then 0x00 with status not_empty = 0.
- Pop edge rule: hold a read of 0x4 for 3 cycles with 2 bytes queued -> exactly one pop; deassert en for 1 cycle, read again -> second byte returned.
